// File: rtl/palette_lut_banked.sv
// ============================================================================
// Module   : palette_lut_banked
// Brief    : Banked, runtime-writable colour palette with a registered lookup,
//            a tear-safe write port and bank swaps applied at frame start.
//            Optional colour cycling when PALETTE_CYCLE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module palette_lut_banked #(
    parameter int INDEX_W    = 4,
    parameter int CH_W       = 4,
    parameter int N_BANKS    = 2,
    parameter int TRANSP_IDX = 0,
    parameter int CYC_LO     = 6,
    parameter int CYC_HI     = 9,
    parameter int CYC_PERIOD = 8,
    localparam int BANK_W    = ($clog2(N_BANKS) > 1) ? $clog2(N_BANKS) : 1
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_start,
    input  logic                blank,
    input  logic                rd_valid,
    input  logic [INDEX_W-1:0]  rd_index,
    output logic                out_valid,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    output logic                out_transparent,
    input  logic                wr_en,
    output logic                wr_ready,
    input  logic [BANK_W-1:0]   wr_bank,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [3*CH_W-1:0]   wr_data,
    input  logic                swap_req,
    input  logic [BANK_W-1:0]   swap_bank,
    output logic [BANK_W-1:0]   active_bank,
    output logic                swap_pending
);

    localparam int                 c_depth  = 2**INDEX_W;
    localparam int                 c_dw     = 3*CH_W;
    localparam logic [INDEX_W-1:0] c_transp = INDEX_W'(TRANSP_IDX);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [BANK_W-1:0]   r_active, w_active_nxt;
    logic [BANK_W-1:0]   r_target, w_target_nxt;
    logic [c_dw-1:0]     r_mem [N_BANKS][c_depth];
    logic [c_dw-1:0]     r_rgb;
    logic                r_out_valid;
    logic                r_transp;
    logic                w_wr_bank_ok;
    logic                w_swap_bank_ok;
    logic                w_wr_commit;
    logic [INDEX_W-1:0]  w_eff_index;

    if (N_BANKS < 2 || CYC_HI < CYC_LO || CYC_PERIOD < 1) begin : g_param_err
        $error("palette_lut_banked: illegal parameter combination");
    end

    // Bank range checks only exist when the bank field can encode unused banks.
    if ((2**BANK_W) > N_BANKS) begin : g_bank_chk
        localparam logic [BANK_W:0] c_nbanks = (BANK_W+1)'(N_BANKS);
        assign w_wr_bank_ok   = ({1'b0, wr_bank}   < c_nbanks);
        assign w_swap_bank_ok = ({1'b0, swap_bank} < c_nbanks);
    end else begin : g_bank_full
        assign w_wr_bank_ok   = 1'b1;
        assign w_swap_bank_ok = 1'b1;
    end

    assign wr_ready    = blank | (wr_bank != r_active);
    assign w_wr_commit = wr_en & wr_ready & w_wr_bank_ok;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int b = 0; b < N_BANKS; b++) begin
                for (int i = 0; i < c_depth; i++) begin
                    r_mem[b][i] <= '0;
                end
            end
        end else if (w_wr_commit) begin
            r_mem[wr_bank][wr_index] <= wr_data;
        end
    end

`ifdef PALETTE_CYCLE_EN
    localparam int                c_fc_w    = (CYC_PERIOD > 1) ? $clog2(CYC_PERIOD) : 1;
    localparam logic [c_fc_w-1:0] c_fc_last = c_fc_w'(CYC_PERIOD - 1);
    localparam logic [INDEX_W:0]  c_lo      = (INDEX_W+1)'(CYC_LO);
    localparam logic [INDEX_W:0]  c_hi      = (INDEX_W+1)'(CYC_HI);
    localparam logic [INDEX_W:0]  c_span    = (INDEX_W+1)'(CYC_HI - CYC_LO + 1);

    logic [c_fc_w-1:0] r_frame_cnt;
    logic [INDEX_W:0]  r_offset;
    logic [INDEX_W:0]  w_rel;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_frame_cnt <= '0;
            r_offset    <= '0;
        end else if (frame_start) begin
            if (r_frame_cnt == c_fc_last) begin
                r_frame_cnt <= '0;
                r_offset    <= (r_offset + 1'b1 == c_span) ? '0 : r_offset + 1'b1;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    // Both terms are below SPAN, so a single conditional subtract is the modulo.
    always_comb begin
        w_eff_index = rd_index;
        w_rel       = {1'b0, rd_index} - c_lo + r_offset;
        if (w_rel >= c_span) begin
            w_rel = w_rel - c_span;
        end
        if (({1'b0, rd_index} >= c_lo) && ({1'b0, rd_index} <= c_hi)) begin
            w_eff_index = INDEX_W'(c_lo + w_rel);
        end
    end
`else
    assign w_eff_index = rd_index;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_out_valid <= 1'b0;
            r_rgb       <= '0;
            r_transp    <= 1'b0;
        end else begin
            r_out_valid <= rd_valid;
            if (rd_valid) begin
                r_rgb    <= r_mem[r_active][w_eff_index];
                r_transp <= (rd_index == c_transp);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= IDLE;
            r_active <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            r_target <= w_target_nxt;
        end
    end

    // A request arriving together with frame_start is the newest, so it wins.
    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_target_nxt = r_target;
        case (r_state)
            IDLE: begin
                if (swap_req && w_swap_bank_ok) begin
                    if (frame_start) begin
                        w_active_nxt = swap_bank;
                    end else begin
                        w_target_nxt = swap_bank;
                        w_state_nxt  = PENDING;
                    end
                end
            end
            PENDING: begin
                if (swap_req && w_swap_bank_ok) begin
                    w_target_nxt = swap_bank;
                end
                if (frame_start) begin
                    w_active_nxt = (swap_req && w_swap_bank_ok) ? swap_bank : r_target;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign out_valid          = r_out_valid;
    assign {red, green, blue} = r_rgb;
    assign out_transparent    = r_transp;
    assign active_bank        = r_active;
    assign swap_pending       = (r_state == PENDING);

endmodule

`default_nettype wire
